// File: rtl/fwrisc_mdu_pkg.sv
// rtl/fwrisc_mdu_pkg.sv - opcodes, FSM states and op-class helpers for the multiply/divide/shift unit
package fwrisc_mdu_pkg;

   typedef enum logic [3:0] {
      OP_SLL    = 4'd0,
      OP_SRL    = 4'd1,
      OP_SRA    = 4'd2,
      OP_MUL    = 4'd4,
      OP_MULH   = 4'd5,
      OP_MULHSU = 4'd6,
      OP_MULHU  = 4'd7,
      OP_DIV    = 4'd8,
      OP_DIVU   = 4'd9,
      OP_REM    = 4'd10,
      OP_REMU   = 4'd11
   } mdu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } mdu_state_e;

   function automatic logic is_shift(logic [3:0] op);
      return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
   endfunction

   function automatic logic is_mul(logic [3:0] op);
      return op[3:2] == 2'b01;
   endfunction

   function automatic logic is_div(logic [3:0] op);
      return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
   endfunction

   function automatic logic is_signed_a(logic [3:0] op);
      return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic is_signed_b(logic [3:0] op);
      return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   endfunction

endpackage

// File: rtl/fwrisc_mdu_if.sv
// rtl/fwrisc_mdu_if.sv - request/response handshake bundle between the execute stage and the MDU
interface fwrisc_mdu_if #(
   parameter int XLEN = 32
);
   logic [XLEN-1:0] in_a;
   logic [XLEN-1:0] in_b;
   logic [3:0]      op;
   logic            in_valid;
   logic            in_ready;
   logic            flush;
   logic [XLEN-1:0] out;
   logic            out_illegal;
   logic            out_valid;
   logic            out_ready;

   modport master (
      output in_a, in_b, op, in_valid, flush, out_ready,
      input  in_ready, out, out_illegal, out_valid
   );

   modport slave (
      input  in_a, in_b, op, in_valid, flush, out_ready,
      output in_ready, out, out_illegal, out_valid
   );
endinterface

// File: rtl/fwrisc_mdu_div.sv
// rtl/fwrisc_mdu_div.sv - unsigned restoring divider, one quotient bit per cycle
// Magnitudes in, magnitudes out; sign handling and special cases belong to the caller.
module fwrisc_mdu_div #(
   parameter int XLEN = 32
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            start,
   input  logic            kill,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder,
   output logic            done
);
   localparam int CW = $clog2(XLEN + 1);

   logic [XLEN-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            busy_q, busy_d, done_q, done_d;
   logic [XLEN:0]   trial, diff;

   always_comb begin
      quo_d  = quo_q;
      rem_d  = rem_q;
      dvs_d  = dvs_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      done_d = done_q;
      // Shift the next dividend bit into the partial remainder and try the subtract.
      trial  = {rem_q, quo_q[XLEN-1]};
      diff   = trial - {1'b0, dvs_q};
      if (kill) begin
         busy_d = 1'b0;
         done_d = 1'b0;
      end else if (start) begin
         quo_d  = dividend;
         rem_d  = '0;
         dvs_d  = divisor;
         cnt_d  = CW'(XLEN);
         busy_d = 1'b1;
         done_d = 1'b0;
      end else if (busy_q) begin
         if (!diff[XLEN]) begin
            rem_d = diff[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b1};
         end else begin
            rem_d = trial[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b0};
         end
         cnt_d = cnt_q - 1'b1;
         if (cnt_q == CW'(1)) begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         quo_q  <= '0;
         rem_q  <= '0;
         dvs_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         quo_q  <= quo_d;
         rem_q  <= rem_d;
         dvs_q  <= dvs_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign quotient  = quo_q;
   assign remainder = rem_q;
   assign done      = done_q;
endmodule

// File: rtl/fwrisc_mdu.sv
// rtl/fwrisc_mdu.sv - multi-cycle multiply/divide/shift unit with valid/ready handshakes and flush
module fwrisc_mdu
   import fwrisc_mdu_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int ENABLE_MUL = 1,
   parameter int ENABLE_DIV = 1,
   parameter int SHIFT_STEP = 1,
   parameter int MUL_STEP   = 1
) (
   input logic          clock,
   input logic          reset,
   fwrisc_mdu_if.slave  bus
);
   localparam int              SHW     = $clog2(XLEN);
   localparam int              MUL_CYC = XLEN / MUL_STEP;
   localparam logic [SHW:0]    SH_STEP = (SHW + 1)'(SHIFT_STEP);
   localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN - 1){1'b0}}};

   mdu_state_e        state_q, state_d;
   logic [3:0]        op_q, op_d;
   logic [XLEN-1:0]   a_q, a_d, b_q, b_d, sh_q, sh_d, mcand_q, mcand_d, out_q, out_d;
   logic [2*XLEN-1:0] prod_q, prod_d;
   logic [SHW-1:0]    shamt_q, shamt_d, cnt_q, cnt_d;
   logic              neg_res_q, neg_res_d, neg_a_q, neg_a_d, illegal_q, illegal_d;

   logic              a_neg, b_neg, op_legal, div_quo_op, div_ovf, div_start, div_done;
   logic [XLEN-1:0]   a_mag, b_mag, sh_step, div_quo, div_rem;
   logic [SHW:0]      sh_amt;
   logic [2*XLEN-1:0] prod_step, prod_fin;
   logic [XLEN:0]     mul_hi;

   // Signed operands are reduced to magnitudes on accept; the result sign is reapplied at the end.
   always_comb begin
      a_neg = is_signed_a(bus.op) && bus.in_a[XLEN-1];
      b_neg = is_signed_b(bus.op) && bus.in_b[XLEN-1];
      a_mag = a_neg ? -bus.in_a : bus.in_a;
      b_mag = b_neg ? -bus.in_b : bus.in_b;
   end

   // Shift datapath: at most SHIFT_STEP bits per cycle, the last step takes what remains.
   always_comb begin
      sh_amt = ({1'b0, shamt_q} > SH_STEP) ? SH_STEP : {1'b0, shamt_q};
      case (op_q)
         OP_SLL:  sh_step = sh_q << sh_amt;
         OP_SRA:  sh_step = $signed(sh_q) >>> sh_amt;
         default: sh_step = sh_q >> sh_amt;
      endcase
   end

   // Shift-add multiplier: multiplier sits in the low half and drains out as the product fills in.
   always_comb begin
      prod_step = prod_q;
      mul_hi    = '0;
      for (int k = 0; k < MUL_STEP; k++) begin
         mul_hi    = {1'b0, prod_step[2*XLEN-1:XLEN]} + (prod_step[0] ? {1'b0, mcand_q} : '0);
         prod_step = {mul_hi, prod_step[XLEN-1:1]};
      end
      prod_fin = neg_res_q ? -prod_step : prod_step;
   end

   always_comb begin
      op_legal   = is_shift(op_q) || (is_mul(op_q) && ENABLE_MUL != 0)
                   || (is_div(op_q) && ENABLE_DIV != 0);
      div_quo_op = (op_q == OP_DIV) || (op_q == OP_DIVU);
      div_ovf    = is_signed_a(op_q) && (a_q == MIN_INT) && (b_q == '1);
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      a_d       = a_q;
      b_d       = b_q;
      sh_d      = sh_q;
      shamt_d   = shamt_q;
      mcand_d   = mcand_q;
      prod_d    = prod_q;
      cnt_d     = cnt_q;
      neg_res_d = neg_res_q;
      neg_a_d   = neg_a_q;
      out_d     = out_q;
      illegal_d = illegal_q;
      div_start = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               state_d   = ST_BUSY;
               op_d      = bus.op;
               a_d       = bus.in_a;
               b_d       = bus.in_b;
               sh_d      = bus.in_a;
               shamt_d   = bus.in_b[SHW-1:0];
               mcand_d   = a_mag;
               prod_d    = {{XLEN{1'b0}}, b_mag};
               cnt_d     = SHW'(MUL_CYC - 1);
               neg_res_d = a_neg ^ b_neg;
               neg_a_d   = a_neg;
               illegal_d = 1'b0;
               div_start = is_div(bus.op);
            end
         end
         ST_BUSY: begin
            if (!op_legal) begin
               out_d     = '0;
               illegal_d = 1'b1;
               state_d   = ST_DONE;
            end else if (is_shift(op_q)) begin
               sh_d    = sh_step;
               shamt_d = shamt_q - sh_amt[SHW-1:0];
               if ({1'b0, shamt_q} == sh_amt) begin
                  out_d   = sh_step;
                  state_d = ST_DONE;
               end
            end else if (is_mul(op_q)) begin
               prod_d = prod_step;
               cnt_d  = cnt_q - 1'b1;
               if (cnt_q == '0) begin
                  out_d   = (op_q == OP_MUL) ? prod_fin[XLEN-1:0] : prod_fin[2*XLEN-1:XLEN];
                  state_d = ST_DONE;
               end
            end else if (b_q == '0) begin
               out_d   = div_quo_op ? '1 : a_q;
               state_d = ST_DONE;
            end else if (div_ovf) begin
               out_d   = div_quo_op ? MIN_INT : '0;
               state_d = ST_DONE;
            end else if (div_done) begin
               out_d   = div_quo_op ? (neg_res_q ? -div_quo : div_quo)
                                    : (neg_a_q ? -div_rem : div_rem);
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (bus.out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (bus.flush) begin
         state_d   = ST_IDLE;
         div_start = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         sh_q      <= '0;
         shamt_q   <= '0;
         mcand_q   <= '0;
         prod_q    <= '0;
         cnt_q     <= '0;
         neg_res_q <= 1'b0;
         neg_a_q   <= 1'b0;
         out_q     <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         a_q       <= a_d;
         b_q       <= b_d;
         sh_q      <= sh_d;
         shamt_q   <= shamt_d;
         mcand_q   <= mcand_d;
         prod_q    <= prod_d;
         cnt_q     <= cnt_d;
         neg_res_q <= neg_res_d;
         neg_a_q   <= neg_a_d;
         out_q     <= out_d;
         illegal_q <= illegal_d;
      end
   end

   // The divider loads on the accept edge so XLEN steps plus the sign-fix edge give XLEN+1.
   if (ENABLE_DIV != 0) begin : g_div
      fwrisc_mdu_div #(.XLEN(XLEN)) u_div (
         .clock     (clock),
         .reset     (reset),
         .start     (div_start),
         .kill      (bus.flush),
         .dividend  (a_mag),
         .divisor   (b_mag),
         .quotient  (div_quo),
         .remainder (div_rem),
         .done      (div_done)
      );
   end else begin : g_no_div
      assign div_quo  = '0;
      assign div_rem  = '0;
      assign div_done = 1'b0;
   end

   assign bus.in_ready    = (state_q == ST_IDLE);
   assign bus.out_valid   = (state_q == ST_DONE);
   assign bus.out         = out_q;
   assign bus.out_illegal = illegal_q;
endmodule

// File: tb/tb_fwrisc_mdu.sv
// tb/tb_fwrisc_mdu.sv - bench for fwrisc_mdu across three parameter sets against a behavioural model
module tb_fwrisc_mdu;
   import fwrisc_mdu_pkg::*;

   logic        clk;
   logic        rst_n;
   logic [31:0] drv_a, drv_b;
   logic [3:0]  drv_op;
   logic        drv_valid, drv_flush, drv_out_ready;
   int          cur;
   int          n_cmp, n_err;

   // u0: default, u1: MUL_STEP=4/SHIFT_STEP=4/no divider, u2: SHIFT_STEP=32/MUL_STEP=2/no multiplier
   int mstep  [3] = '{1, 4, 2};
   int sstep  [3] = '{1, 4, 32};
   int en_mul [3] = '{1, 1, 0};
   int en_div [3] = '{1, 0, 1};

   fwrisc_mdu_if #(.XLEN(32)) if0 ();
   fwrisc_mdu_if #(.XLEN(32)) if1 ();
   fwrisc_mdu_if #(.XLEN(32)) if2 ();

   fwrisc_mdu #(.XLEN(32)) u0 (.clock(clk), .reset(rst_n), .bus(if0));
   fwrisc_mdu #(.XLEN(32), .ENABLE_DIV(0), .SHIFT_STEP(4), .MUL_STEP(4)) u1 (.clock(clk), .reset(rst_n), .bus(if1));
   fwrisc_mdu #(.XLEN(32), .ENABLE_MUL(0), .SHIFT_STEP(32), .MUL_STEP(2)) u2 (.clock(clk), .reset(rst_n), .bus(if2));

   assign if0.in_a = drv_a;  assign if1.in_a = drv_a;  assign if2.in_a = drv_a;
   assign if0.in_b = drv_b;  assign if1.in_b = drv_b;  assign if2.in_b = drv_b;
   assign if0.op   = drv_op; assign if1.op   = drv_op; assign if2.op   = drv_op;
   assign if0.flush = drv_flush; assign if1.flush = drv_flush; assign if2.flush = drv_flush;
   assign if0.out_ready = drv_out_ready; assign if1.out_ready = drv_out_ready; assign if2.out_ready = drv_out_ready;
   assign if0.in_valid = drv_valid && (cur == 0);
   assign if1.in_valid = drv_valid && (cur == 1);
   assign if2.in_valid = drv_valid && (cur == 2);

   logic [31:0] o_out;
   logic        o_valid, o_ill, o_rdy;
   assign o_out   = (cur == 0) ? if0.out : (cur == 1) ? if1.out : if2.out;
   assign o_valid = (cur == 0) ? if0.out_valid : (cur == 1) ? if1.out_valid : if2.out_valid;
   assign o_ill   = (cur == 0) ? if0.out_illegal : (cur == 1) ? if1.out_illegal : if2.out_illegal;
   assign o_rdy   = (cur == 0) ? if0.in_ready : (cur == 1) ? if1.in_ready : if2.in_ready;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain RV semantics via wide arithmetic, {illegal, result}
   function automatic logic [32:0] model(input int s, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
      logic [63:0] p;
      logic [31:0] r;
      int          sh;
      longint      sx, sy;
      sh = int'(y[4:0]);
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      r  = '0;
      p  = '0;
      case (o)
         4'd0: r = x << sh;
         4'd1: r = x >> sh;
         4'd2: r = $signed(x) >>> sh;
         4'd4, 4'd5, 4'd6, 4'd7: begin
            if (en_mul[s] == 0) return {1'b1, 32'h0};
            if (o == 4'd7) p = {32'h0, x} * {32'h0, y};
            else if (o == 4'd6) p = sx * longint'({32'h0, y});
            else p = sx * sy;
            r = (o == 4'd4) ? p[31:0] : p[63:32];
         end
         4'd8, 4'd9, 4'd10, 4'd11: begin
            if (en_div[s] == 0) return {1'b1, 32'h0};
            if (y == 0) r = (o == 4'd8 || o == 4'd9) ? 32'hFFFF_FFFF : x;
            else if ((o == 4'd8 || o == 4'd10) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
               r = (o == 4'd8) ? 32'h8000_0000 : 32'h0;
            else if (o == 4'd8)  r = 32'(int'(x) / int'(y));
            else if (o == 4'd10) r = 32'(int'(x) % int'(y));
            else if (o == 4'd9)  r = x / y;
            else                 r = x % y;
         end
         default: return {1'b1, 32'h0};
      endcase
      return {1'b0, r};
   endfunction

   function automatic int exp_lat(input int s, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
      int sh;
      sh = int'(y[4:0]);
      if (o <= 4'd2) return (sh == 0) ? 1 : (sh + sstep[s] - 1) / sstep[s];
      if (o >= 4'd4 && o <= 4'd7) return (en_mul[s] != 0) ? 32 / mstep[s] : 1;
      if (o >= 4'd8 && o <= 4'd11) begin
         if (en_div[s] == 0 || y == 0) return 1;
         if ((o == 4'd8 || o == 4'd10) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
         return 33;
      end
      return 1;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!o_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic run_op(input int s, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] res, output logic ill, output int lat);
      @(negedge clk);
      cur = s; drv_op = o; drv_a = x; drv_b = y; drv_valid = 1'b1;
      @(posedge clk); #1;
      drv_valid = 1'b0; drv_a = $urandom; drv_b = $urandom; drv_op = 4'($urandom);
      wait_valid(lat);
      res = o_out;
      ill = o_ill;
      @(posedge clk); #1;
   endtask

   task automatic expect_op(input int s, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                            input logic [31:0] er, input logic ei, input int el, input string tag);
      logic [31:0] res;
      logic        ill;
      int          lat;
      run_op(s, o, x, y, res, ill, lat);
      chk({tag, "_res"}, 64'(res), 64'(er));
      chk({tag, "_ill"}, 64'(ill), 64'(ei));
      chk({tag, "_lat"}, 64'(lat), 64'(el));
   endtask

   initial begin
      logic [32:0] m;
      logic [3:0]  ro;
      logic [31:0] ra, rb;
      int          lat;
      logic        ok, seen;
      n_cmp = 0; n_err = 0; cur = 0;
      drv_a = '0; drv_b = '0; drv_op = '0; drv_valid = 1'b0; drv_flush = 1'b0; drv_out_ready = 1'b1;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 64'({if0.in_ready, if1.in_ready, if2.in_ready}), 64'(3'b111));
      chk("rst_out_valid", 64'({if0.out_valid, if1.out_valid, if2.out_valid}), 64'(3'b000));
      chk("rst_out", 64'({if0.out, if1.out, if2.out} != 0), 64'(0));
      chk("rst_illegal", 64'({if0.out_illegal, if1.out_illegal, if2.out_illegal}), 64'(3'b000));
      @(negedge clk); rst_n = 1'b1;

      expect_op(0, OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 32, "mul_s1");
      expect_op(1, OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 8, "mul_s4");
      expect_op(0, OP_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 32, "mulh_min");
      expect_op(0, OP_MULHU, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 32, "mulhu_min");
      expect_op(0, OP_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 1'b0, 32, "mulhsu");
      expect_op(0, OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 32, "mulhu_max");
      expect_op(0, OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 33, "div_neg");
      expect_op(0, OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 33, "rem_neg");
      expect_op(0, OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0, 1, "divu_zero");
      expect_op(0, OP_REM, 32'd5, 32'd0, 32'd5, 1'b0, 1, "rem_zero");
      expect_op(0, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1, "div_ovf");
      expect_op(0, OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0, 1, "rem_ovf");
      expect_op(0, OP_SRA, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0, 31, "sra_s1");
      expect_op(1, OP_SRA, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0, 8, "sra_s4");
      expect_op(2, OP_SRA, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0, 1, "sra_s32");
      expect_op(0, OP_SLL, 32'h1, 32'd0, 32'h1, 1'b0, 1, "sll_zero");
      expect_op(1, OP_SRL, 32'hF0, 32'd5, 32'h7, 1'b0, 2, "srl_s4");
      expect_op(1, OP_DIV, 32'd100, 32'd7, 32'h0, 1'b1, 1, "div_disabled");
      expect_op(2, OP_MUL, 32'd3, 32'd4, 32'h0, 1'b1, 1, "mul_disabled");
      expect_op(0, 4'd13, 32'd3, 32'd4, 32'h0, 1'b1, 1, "op_unknown");

      // Backpressure: result held while a second request waits on in_ready.
      drv_out_ready = 1'b0;
      @(negedge clk); cur = 0; drv_op = OP_MUL; drv_a = 32'd3; drv_b = 32'd5; drv_valid = 1'b1;
      @(posedge clk); #1;
      drv_valid = 1'b0;
      wait_valid(lat);
      chk("bp_lat", 64'(lat), 64'(32));
      @(negedge clk); drv_op = OP_DIVU; drv_a = 32'd100; drv_b = 32'd7; drv_valid = 1'b1;
      ok = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (o_out !== 32'd15 || o_valid !== 1'b1 || o_rdy !== 1'b0) ok = 1'b0;
      end
      chk("bp_hold", 64'(ok), 64'(1));
      @(negedge clk); drv_out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_ready", 64'(o_rdy), 64'(1));
      chk("bp_valid_drop", 64'(o_valid), 64'(0));
      @(posedge clk); #1;
      drv_valid = 1'b0;
      wait_valid(lat);
      chk("bp2_res", 64'(o_out), 64'(14));
      chk("bp2_lat", 64'(lat), 64'(33));
      @(posedge clk); #1;

      // Flush during a divide.
      @(negedge clk); cur = 0; drv_op = OP_DIV; drv_a = 32'd1000; drv_b = 32'd3; drv_valid = 1'b1;
      @(posedge clk); #1;
      drv_valid = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk); drv_flush = 1'b1;
      @(posedge clk); #1;
      drv_flush = 1'b0;
      chk("flush_ready", 64'(o_rdy), 64'(1));
      chk("flush_valid", 64'(o_valid), 64'(0));
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (o_valid) seen = 1'b1;
      end
      chk("flush_stale", 64'(seen), 64'(0));

      // Asynchronous reset in the middle of a multiply.
      @(negedge clk); cur = 0; drv_op = OP_MUL; drv_a = 32'd123; drv_b = 32'd456; drv_valid = 1'b1;
      @(posedge clk); #1;
      drv_valid = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk); rst_n = 1'b0;
      #1;
      chk("arst_ready", 64'(o_rdy), 64'(1));
      chk("arst_valid", 64'(o_valid), 64'(0));
      chk("arst_out", 64'(o_out), 64'(0));
      @(negedge clk); rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (o_valid) seen = 1'b1;
      end
      chk("arst_stale", 64'(seen), 64'(0));
      expect_op(0, OP_MUL, 32'd123, 32'd456, 32'd56088, 1'b0, 32, "arst_recover");

      for (int s = 0; s < 3; s++) begin
         for (int i = 0; i < 25; i++) begin
            ro = 4'($urandom_range(0, 15));
            ra = pick();
            rb = pick();
            m  = model(s, ro, ra, rb);
            expect_op(s, ro, ra, rb, m[31:0], m[32], exp_lat(s, ro, ra, rb),
                      $sformatf("rnd_u%0d_%0d_op%0d_%h_%h", s, i, ro, ra, rb));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/fwrisc_mdu.md
Name: fwrisc_mdu

Overview:
Parametrised multi-cycle multiply/divide/shift unit, the successor to the current fixed-32-bit iterative unit. Implements the full RV M-extension set plus SLL/SRL/SRA. Width and per-cycle step sizes are configurable. Uses valid/ready handshakes on both sides and has a flush input. Sits beside the ALU in the execute stage; the core stalls on in_ready/out_valid.

Parameters:
XLEN, 32, datapath width (32 or 64).
ENABLE_MUL, 1, multiply ops implemented; 0 = ops reported illegal.
ENABLE_DIV, 1, divide/remainder ops implemented; 0 = ops reported illegal.
SHIFT_STEP, 1, bits shifted per cycle (power of 2, 1..XLEN; XLEN = single-cycle shift).
MUL_STEP, 1, multiplier bits retired per cycle (1, 2 or 4; must divide XLEN).

Ports:
clock  input  1  clock
reset  input  1  asynchronous, active-low reset
in_a  input  XLEN  operand A (rs1)
in_b  input  XLEN  operand B (rs2); shifts use in_b[log2(XLEN)-1:0]
op  input  4  operation code (fwrisc_mdu_pkg::mdu_op_e)
in_valid  input  1  request valid
in_ready  output  1  unit can accept a request
flush  input  1  abandon the current operation
out  output  XLEN  result
out_illegal  output  1  op disabled or unknown; qualified by out_valid
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result

Behaviour:
- Reset (async, active-low): state=IDLE, out=0, out_valid=0, out_illegal=0, in_ready=1. All working registers cleared.
- FSM states: IDLE, BUSY, DONE.
- in_ready = (state==IDLE). Request accepted on a rising edge with in_valid && in_ready; operands and op are registered then, so inputs may change afterwards.
- IDLE -> BUSY on accept. In BUSY a step counter runs; BUSY -> DONE after the final step, with out_valid=1 from the DONE entry edge.
- Latency L = edges from accept to out_valid=1:
  - shift: max(1, ceil(shamt/SHIFT_STEP))
  - mul ops: XLEN/MUL_STEP
  - div ops: XLEN+1 (XLEN restoring steps plus one sign-fix step)
  - div by zero, signed overflow, illegal op: L=1
- DONE: out and out_illegal are held stable while out_valid && !out_ready. DONE -> IDLE on out_valid && out_ready, so in_ready=1 on the following cycle. No same-cycle re-accept.
- flush: from any state, next edge -> IDLE, out_valid=0. Flush has priority over accept and completion. A flushed result is never presented.
- Shifts: SRA sign-fills from in_a[XLEN-1]. shamt=0 returns in_a. The final step shifts by the remaining amount (shamt mod SHIFT_STEP) so non-multiple amounts are exact.
- MUL: low XLEN bits of the product. MULH = signed x signed high half; MULHSU = signed A x unsigned B high half; MULHU = unsigned x unsigned high half. Internal product register is 2*XLEN wide. Signed ops use magnitude multiply plus final negate, or sign-extended partial products; either is acceptable if results are bit-exact.
- DIV/DIVU/REM/REMU follow the RISC-V spec:
  - quotient truncates toward zero; remainder takes the sign of the dividend
  - divide by zero: DIV/DIVU give all-ones, REM/REMU give in_a
  - signed overflow (min_int / -1): DIV gives min_int, REM gives 0
- Disabled or unknown op: out=0, out_illegal=1.
- An in_valid held during BUSY/DONE is ignored (not accepted) until in_ready=1.

Decomposition:
- Package fwrisc_mdu_pkg: mdu_op_e enum with OP_SLL=0, OP_SRL=1, OP_SRA=2, OP_MUL=4, OP_MULH=5, OP_MULHSU=6, OP_MULHU=7, OP_DIV=8, OP_DIVU=9, OP_REM=10, OP_REMU=11; mdu_state_e; helpers is_mul(op), is_div(op), is_signed_a/b(op).
- Sub-module fwrisc_mdu_div: restoring divider with start/done, XLEN-parametrised, returning quotient and remainder magnitudes. The top level owns sign handling and special cases.

Test Plan:
1. XLEN=32, MUL 7 x 0xFFFFFFFD -> out=0xFFFFFFEB, out_valid exactly 32 edges after accept; MUL_STEP=4 -> 8 edges.
2. MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU same operands -> 0x40000000; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
3. DIV 0xFFFFFFF9(-7) / 2 -> 0xFFFFFFFD in 33 edges; REM same -> 0xFFFFFFFF; DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, both in 1 edge; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0.
4. SRA 0x80000000 by 31 -> 0xFFFFFFFF: 31 edges at SHIFT_STEP=1, 8 at SHIFT_STEP=4, 1 at SHIFT_STEP=32; SLL 0x1 by 0 -> 0x1 in 1 edge; SRL 0xF0 by 5, SHIFT_STEP=4 -> 0x7.
5. Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out stable, in_ready=0, a second in_valid is not accepted; raise out_ready -> in_ready=1 next cycle, second op then completes correctly.
6. Assert flush at BUSY step 10 of a DIV, then assert reset low mid-MUL -> both return to IDLE with out_valid=0 and no stale result; with ENABLE_DIV=0, DIV -> out=0, out_illegal=1 after 1 edge.
